// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- request/response bundle for the sequential RV32M unit.
//   start     : one-cycle request, sampled on rising clk
//   funct3    : RV32M operation select
//   rs1_data  : dividend / multiplicand
//   rs2_data  : divisor / multiplier
//   flush     : abort the in-flight operation
//   busy      : accepted operation not yet finished
//   valid     : one-cycle pulse, result is valid
//   result    : operation result, held until the next valid
interface muldiv_seq_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative RV32M multiply/divide unit.
// One radix-2 step per cycle over 32 cycles: shift-add multiply and restoring
// divide, both on operand magnitudes with the sign fixed up at the end.
// Divide-by-zero and signed overflow skip the iterations entirely.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_seq_if.slave request/response bundle
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start
// CALC   | iterating, cnt_q = step index 0..31
// DONE   | result presented for one cycle (valid unless flushed)
module muldiv_seq (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        rneg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] b_q;
    logic [31:0] res_pend_q;
    logic [31:0] result_q;

    logic        s1_in;
    logic        s2_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] bypass_val;

    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] final_val;

    // Operand sign flags only apply to the signed variants.
    always_comb begin
        s1_in = 1'b0;
        s2_in = 1'b0;
        case (bus.funct3)
            3'b001: begin s1_in = bus.rs1_data[31]; s2_in = bus.rs2_data[31]; end
            3'b010: begin s1_in = bus.rs1_data[31]; end
            3'b100,
            3'b110: begin s1_in = bus.rs1_data[31]; s2_in = bus.rs2_data[31]; end
            default: ;
        endcase
    end

    assign a_mag = s1_in ? (32'd0 - bus.rs1_data) : bus.rs1_data;
    assign b_mag = s2_in ? (32'd0 - bus.rs2_data) : bus.rs2_data;

    assign div_zero = bus.funct3[2] && (bus.rs2_data == 32'd0);
    assign div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);

    always_comb begin
        bypass_val = 32'd0;
        if (div_zero)
            bypass_val = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
        else if (div_ovf)
            bypass_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // hi_q/lo_q hold {accumulator, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide; b_q is the other operand.
    assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign rem_shift = {hi_q, lo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, b_q};

    always_comb begin
        if (op_q[2]) begin
            if (!rem_diff[32]) begin
                hi_n = rem_diff[31:0];
                lo_n = {lo_q[30:0], 1'b1};
            end else begin
                hi_n = rem_shift[31:0];
                lo_n = {lo_q[30:0], 1'b0};
            end
        end else begin
            hi_n = add_sum[32:1];
            lo_n = {add_sum[0], lo_q[31:1]};
        end
    end

    always_comb begin
        prod_s = neg_q ? (64'd0 - {hi_n, lo_n}) : {hi_n, lo_n};
        quo_s  = neg_q ? (32'd0 - lo_n) : lo_n;
        rem_s  = rneg_q ? (32'd0 - hi_n) : hi_n;
        if (op_q[2])
            final_val = op_q[1] ? rem_s : quo_s;
        else
            final_val = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            op_q       <= 3'd0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            b_q        <= 32'd0;
            res_pend_q <= 32'd0;
            result_q   <= 32'd0;
        end else if (bus.flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.funct3;
                        neg_q  <= s1_in ^ s2_in;
                        rneg_q <= s1_in;
                        hi_q   <= 32'd0;
                        lo_q   <= a_mag;
                        b_q    <= b_mag;
                        cnt_q  <= 5'd0;
                        if (div_zero || div_ovf) begin
                            res_pend_q <= bypass_val;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        res_pend_q <= final_val;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_q <= res_pend_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A flush in the DONE cycle must hide the new value, hence the bypass
    // mux rather than a plain registered result.
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.valid  = (state_q == S_DONE) && !bus.flush;
    assign bus.result = bus.valid ? res_pend_q : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] last_res;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency is counted inclusively: the start cycle through the valid cycle.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.rs1_data = a; bus.rs2_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.rs1_data = 32'd0; bus.rs2_data = 32'd0;
        n = 0; got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (bus.valid) got = 1'b1;
        end
        check({name, " valid_seen"}, 32'(got), 32'd1);
        check({name, " result"}, bus.result, exp);
        check({name, " latency"}, 32'(n + 1), 32'(lat));
        check({name, " busy_in_done"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({name, " valid_after"}, 32'(bus.valid), 32'd0);
        check({name, " busy_after"}, 32'(bus.busy), 32'd0);
        check({name, " result_hold"}, bus.result, exp);
        last_res = exp;
    endtask

    initial begin
        int nvalid;
        checks = 0; errors = 0; last_res = 32'd0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
        bus.rs1_data = 32'd0; bus.rs2_data = 32'd0;
        rst_n = 1'b0;

        vecs[0]  = '{"mul_7_m6",     3'b000, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 34};
        vecs[1]  = '{"mulh_7_m6",    3'b001, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFFF, 34};
        vecs[2]  = '{"mulhu_7_m6",   3'b011, 32'd7,          32'hFFFF_FFFA, 32'h0000_0006, 34};
        vecs[3]  = '{"div_m20_3",    3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34};
        vecs[4]  = '{"rem_m20_3",    3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34};
        vecs[5]  = '{"divu_20_3",    3'b101, 32'd20,         32'd3,         32'd6,         34};
        vecs[6]  = '{"remu_20_3",    3'b111, 32'd20,         32'd3,         32'd2,         34};
        vecs[7]  = '{"divu_by0",     3'b101, 32'h0000_0055,  32'd0,         32'hFFFF_FFFF, 2};
        vecs[8]  = '{"rem_by0",      3'b110, 32'h1234_5678,  32'd0,         32'h1234_5678, 2};
        vecs[9]  = '{"div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[10] = '{"rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[11] = '{"mul_zero_a",   3'b000, 32'd0,          32'h0001_2345, 32'd0,         34};
        vecs[12] = '{"mul_zero_b",   3'b000, 32'h0001_2345,  32'd0,         32'd0,         34};
        vecs[13] = '{"mulhsu_m1_m1", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[14] = '{"mulh_min_min", 3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[15] = '{"mulh_m1_m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[16] = '{"divu_max_1",   3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};
        vecs[17] = '{"remu_7_10",    3'b111, 32'd7,          32'd10,        32'd7,         34};
        vecs[18] = '{"div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[19] = '{"rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34};

        #12;
        check("reset_busy",   32'(bus.busy),  32'd0);
        check("reset_valid",  32'(bus.valid), 32'd0);
        check("reset_result", bus.result,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000;
        bus.rs1_data = 32'd2; bus.rs2_data = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("start_flush_busy", 32'(bus.busy), 32'd0);

        // flush at CALC counter 10
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", 32'(bus.busy), 32'd0);
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.valid) nvalid++;
            @(negedge clk);
        end
        check("flush_no_valid", 32'(nvalid), 32'd0);
        check("flush_result_kept", bus.result, last_res);
        run_op("mul_3_5_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 34);

        // repeated start while busy: only the first op completes
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd4; bus.rs2_data = 32'd5;
        @(posedge clk);
        #1;
        bus.rs1_data = 32'd9;
        nvalid = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.valid) begin
                nvalid++;
                check("spam_result", bus.result, 32'd20);
            end
            bus.start = bus.busy;
        end
        bus.start = 1'b0;
        check("spam_one_valid", 32'(nvalid), 32'd1);
        check("spam_idle", 32'(bus.busy), 32'd0);
        last_res = 32'd20;

        // flush during the DONE cycle of a bypass op
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_data = 32'd77; bus.rs2_data = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("done_flush_valid",  32'(bus.valid), 32'd0);
        check("done_flush_result", bus.result, last_res);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("done_flush_busy",   32'(bus.busy), 32'd0);
        check("done_flush_kept",   bus.result, last_res);

        // async reset at CALC counter 20
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",   32'(bus.busy),  32'd0);
        check("rst_mid_valid",  32'(bus.valid), 32'd0);
        check("rst_mid_result", bus.result,     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.funct3 = 3'b010;
        bus.rs1_data = 32'hFFFF_FFFF; bus.rs2_data = 32'hFFFF_FFFF;
        begin
            int n;
            bit got;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n = 0; got = 1'b0;
            while (n < 60 && !got) begin
                @(negedge clk);
                n++;
                if (bus.valid) got = 1'b1;
            end
            check("post_rst_valid_seen", 32'(got), 32'd1);
            check("post_rst_mulhsu", bus.result, 32'hFFFF_FFFF);
            check("post_rst_latency", 32'(n + 1), 32'd34);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
